// File: rtl/mul_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mul_issue_ctrl (+ mul_issue_pkg)
// Description : Issue/writeback control between the multiply reservation
//               station and a shift-add multiplier, with CDB broadcast.
// Revision    : 1.0 - initial release
// ============================================================================

package mul_issue_pkg;
  localparam int BR_TAG_W = 4;

  typedef struct packed {
    logic                sign;
    logic [BR_TAG_W-1:0] tag;
  } branch_tag_t;
endpackage

module mul_issue_ctrl
  import mul_issue_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int ROB_IDX_W = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 issue_valid,
  output logic                 issue_ready,
  input  logic [2:0]           issue_funct3,
  input  logic [XLEN-1:0]      issue_rs1,
  input  logic [XLEN-1:0]      issue_rs2,
  input  logic [ROB_IDX_W-1:0] issue_rob_idx,
  input  branch_tag_t          issue_br_tag,
  input  logic                 flush,
  input  branch_tag_t          flush_tag,
  output logic                 mul_start,
  output logic [1:0]           mul_type,
  output logic [XLEN-1:0]      mul_a,
  output logic [XLEN-1:0]      mul_b,
  output branch_tag_t          mul_br_tag,
  input  logic [2*XLEN-1:0]    mul_p,
  input  logic                 mul_done,
  output logic                 mul_result_taken,
  output logic                 cdb_req,
  input  logic                 cdb_grant,
  output logic [ROB_IDX_W-1:0] cdb_rob_idx,
  output logic [XLEN-1:0]      cdb_data
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [1:0]             r_mul_type;
  logic [XLEN-1:0]        r_a;
  logic [XLEN-1:0]        r_b;
  logic [XLEN-1:0]        r_result;
  logic [ROB_IDX_W-1:0]   r_rob_idx;
  branch_tag_t            r_tag;
  logic                   r_sel_lo;
  logic [BR_TAG_W-1:0]    w_tag_and;
  logic                   w_match;
  logic                   w_kill;
  logic                   w_accept;
  logic [1:0]             w_type;

  // Same-sign flush kills descendants of the flushed tag; opposite sign kills ancestors.
  always_comb begin
    w_tag_and = r_tag.tag & flush_tag.tag;
    if (r_tag.sign == flush_tag.sign) w_match = (w_tag_and == flush_tag.tag);
    else                              w_match = (w_tag_and == r_tag.tag);
  end

  assign w_kill = flush && w_match;

  always_comb begin
    case (issue_funct3)
      3'b001:  w_type = 2'b01;
      3'b010:  w_type = 2'b10;
      default: w_type = 2'b00;
    endcase
  end

  always_comb begin
    w_state_nxt      = r_state;
    issue_ready      = 1'b0;
    mul_start        = 1'b0;
    mul_result_taken = 1'b0;
    cdb_req          = 1'b0;
    case (r_state)
      S_IDLE: begin
        issue_ready = rst_n && !flush;
        if (issue_valid && rst_n && !flush) w_state_nxt = S_START;
      end
      S_START: begin
        // Start is withheld on any flush: the multiplier checks flush against a stale tag while idle.
        mul_start = !flush;
        if (w_kill)      w_state_nxt = S_IDLE;
        else if (!flush) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (w_kill) begin
          w_state_nxt = S_IDLE;
        end else if (mul_done) begin
          mul_result_taken = 1'b1;
          w_state_nxt      = S_RESP;
        end
      end
      S_RESP: begin
        cdb_req = !w_kill;
        if (w_kill || cdb_grant) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_accept = issue_valid && issue_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_mul_type <= 2'b00;
      r_a        <= '0;
      r_b        <= '0;
      r_result   <= '0;
      r_rob_idx  <= '0;
      r_tag      <= '0;
      r_sel_lo   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_mul_type <= w_type;
        r_a        <= issue_rs1;
        r_b        <= issue_rs2;
        r_rob_idx  <= issue_rob_idx;
        r_tag      <= issue_br_tag;
        r_sel_lo   <= (issue_funct3 == 3'b000);
      end
      if (mul_result_taken) begin
        r_result <= r_sel_lo ? mul_p[XLEN-1:0] : mul_p[2*XLEN-1:XLEN];
      end
    end
  end

  assign mul_type    = r_mul_type;
  assign mul_a       = r_a;
  assign mul_b       = r_b;
  assign mul_br_tag  = r_tag;
  assign cdb_rob_idx = r_rob_idx;
  assign cdb_data    = r_result;

endmodule

`default_nettype wire

// File: tb/tb_mul_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_issue_ctrl
// Description : Self-checking bench for mul_issue_ctrl with a mock multiplier.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_mul_issue_ctrl;
  import mul_issue_pkg::*;

  localparam int XLEN      = 32;
  localparam int ROB_IDX_W = 5;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 issue_valid = 1'b0;
  logic                 issue_ready;
  logic [2:0]           issue_funct3 = '0;
  logic [XLEN-1:0]      issue_rs1 = '0;
  logic [XLEN-1:0]      issue_rs2 = '0;
  logic [ROB_IDX_W-1:0] issue_rob_idx = '0;
  branch_tag_t          issue_br_tag = '0;
  logic                 flush = 1'b0;
  branch_tag_t          flush_tag = '0;
  logic                 mul_start;
  logic [1:0]           mul_type;
  logic [XLEN-1:0]      mul_a;
  logic [XLEN-1:0]      mul_b;
  branch_tag_t          mul_br_tag;
  logic [2*XLEN-1:0]    mul_p = '0;
  logic                 mul_done = 1'b0;
  logic                 mul_result_taken;
  logic                 cdb_req;
  logic                 cdb_grant = 1'b0;
  logic [ROB_IDX_W-1:0] cdb_rob_idx;
  logic [XLEN-1:0]      cdb_data;

  int total = 0;
  int bad   = 0;
  int start_cnt = 0;
  int taken_cnt = 0;
  int m_lat = 3;

  logic            m_busy = 1'b0;
  int              m_cnt = 0;
  branch_tag_t     m_tag = '0;
  logic [XLEN-1:0] m_a = '0;
  logic [XLEN-1:0] m_b = '0;

  mul_issue_ctrl #(.XLEN(XLEN), .ROB_IDX_W(ROB_IDX_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_funct3(issue_funct3),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_rob_idx(issue_rob_idx),
    .issue_br_tag(issue_br_tag), .flush(flush), .flush_tag(flush_tag),
    .mul_start(mul_start), .mul_type(mul_type), .mul_a(mul_a), .mul_b(mul_b),
    .mul_br_tag(mul_br_tag), .mul_p(mul_p), .mul_done(mul_done),
    .mul_result_taken(mul_result_taken), .cdb_req(cdb_req), .cdb_grant(cdb_grant),
    .cdb_rob_idx(cdb_rob_idx), .cdb_data(cdb_data)
  );

  always #5 clk = ~clk;

  function automatic logic tag_match(input branch_tag_t lat, input branch_tag_t ft);
    if (lat.sign == ft.sign) return ((lat.tag & ft.tag) == ft.tag);
    return ((lat.tag & ft.tag) == lat.tag);
  endfunction

  // Mock multiplier: product computed from whatever mul_type the DUT presents at completion.
  function automatic logic [63:0] mock_prod(input logic [1:0] t, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb;
    ea = (t != 2'b00) ? {{32{a[31]}}, a} : {32'b0, a};
    eb = (t == 2'b01) ? {{32{b[31]}}, b} : {32'b0, b};
    return ea * eb;
  endfunction

  // Architectural RV32M result straight from funct3 semantics.
  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint      ps;
    logic [63:0] pu;
    logic [31:0] lo;
    case (f3)
      3'd0: begin lo = a * b; return lo; end
      3'd1: begin ps = longint'($signed(a)) * longint'($signed(b)); return ps[63:32]; end
      3'd2: begin ps = longint'($signed(a)) * longint'({32'b0, b}); return ps[63:32]; end
      default: begin pu = 64'(a) * 64'(b); return pu[63:32]; end
    endcase
  endfunction

  function automatic logic [1:0] exp_type(input logic [2:0] f3);
    return (f3 == 3'd1) ? 2'b01 : (f3 == 3'd2) ? 2'b10 : 2'b00;
  endfunction

  always @(posedge clk) begin
    if (mul_start)        start_cnt <= start_cnt + 1;
    if (mul_result_taken) taken_cnt <= taken_cnt + 1;
  end

  always @(posedge clk) begin
    mul_done <= 1'b0;
    if (!rst_n) begin
      m_busy <= 1'b0;
    end else if (m_busy && flush && tag_match(m_tag, flush_tag)) begin
      m_busy <= 1'b0;
    end else if (mul_start) begin
      m_busy <= 1'b1;
      m_cnt  <= m_lat;
      m_tag  <= mul_br_tag;
      m_a    <= mul_a;
      m_b    <= mul_b;
    end else if (m_busy) begin
      if (m_cnt <= 1) begin
        m_busy   <= 1'b0;
        mul_done <= 1'b1;
        mul_p    <= mock_prod(mul_type, m_a, m_b);
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  // Tasks enter and leave 1 time unit after a falling edge.
  task automatic accept_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rob, input branch_tag_t tag, input string nm,
                           output int s0, output int t0);
    @(negedge clk);
    issue_valid = 1'b1; issue_funct3 = f3; issue_rs1 = a; issue_rs2 = b;
    issue_rob_idx = rob; issue_br_tag = tag;
    #1;
    total++;
    if (issue_ready !== 1'b1) begin bad++; $display("FAIL %s accept: issue_ready got %b want 1", nm, issue_ready); end
    s0 = start_cnt; t0 = taken_cnt;
    @(negedge clk);
    issue_valid = 1'b0;
    #1;
  endtask

  task automatic check_start(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                             input branch_tag_t tag, input string nm);
    total++;
    if (mul_start !== 1'b1 || mul_type !== exp_type(f3) || mul_a !== a || mul_b !== b || mul_br_tag !== tag) begin
      bad++;
      $display("FAIL %s start: start/type/a/b/tag got %b/%b/%h/%h/%h want 1/%b/%h/%h/%h",
               nm, mul_start, mul_type, mul_a, mul_b, mul_br_tag, exp_type(f3), a, b, tag);
    end
  endtask

  task automatic finish_op(input logic [31:0] exp, input logic [4:0] rob, input int s0, input int t0,
                           input int gdelay, input string nm);
    int k;
    k = 0;
    while (cdb_req !== 1'b1 && k < 200) begin @(negedge clk); #1; k++; end
    total++;
    if (cdb_req !== 1'b1) begin bad++; $display("FAIL %s cdb_req timeout: got %b want 1", nm, cdb_req); end
    total++;
    if (cdb_data !== exp || cdb_rob_idx !== rob) begin
      bad++; $display("FAIL %s result: data/rob got %h/%0d want %h/%0d", nm, cdb_data, cdb_rob_idx, exp, rob);
    end
    total++;
    if (start_cnt - s0 != 1) begin bad++; $display("FAIL %s start pulses: got %0d want 1", nm, start_cnt - s0); end
    for (int i = 0; i < gdelay; i++) begin
      @(negedge clk); #1;
      total++;
      if (cdb_req !== 1'b1 || cdb_data !== exp || cdb_rob_idx !== rob || issue_ready !== 1'b0) begin
        bad++;
        $display("FAIL %s hold: req/data/rob/ready got %b/%h/%0d/%b want 1/%h/%0d/0",
                 nm, cdb_req, cdb_data, cdb_rob_idx, issue_ready, exp, rob);
      end
    end
    cdb_grant = 1'b1;
    @(negedge clk);
    cdb_grant = 1'b0;
    #1;
    total++;
    if (issue_ready !== 1'b1 || cdb_req !== 1'b0) begin
      bad++; $display("FAIL %s post-grant: ready/req got %b/%b want 1/0", nm, issue_ready, cdb_req);
    end
    total++;
    if (taken_cnt - t0 != 1) begin bad++; $display("FAIL %s taken pulses: got %0d want 1", nm, taken_cnt - t0); end
  endtask

  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rob, input branch_tag_t tag, input int gdelay, input string nm);
    int s0, t0;
    accept_op(f3, a, b, rob, tag, nm, s0, t0);
    check_start(f3, a, b, tag, nm);
    finish_op(ref_result(f3, a, b), rob, s0, t0, gdelay, nm);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if ({issue_ready, mul_start, mul_type, mul_a, mul_b, mul_br_tag, mul_result_taken,
         cdb_req, cdb_rob_idx, cdb_data} !== '0) begin
      bad++; $display("FAIL reset outputs: got nonzero (ready=%b data=%h) want all 0", issue_ready, cdb_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if (issue_ready !== 1'b1) begin bad++; $display("FAIL reset release: issue_ready got %b want 1", issue_ready); end
  endtask

  task automatic test_directed();
    m_lat = 4;
    run_op(3'd0, 32'd7,        32'hFFFFFFFD, 5'd3,  '{sign: 1'b0, tag: 4'h1}, 0, "mul_neg");
    run_op(3'd1, 32'h80000000, 32'h80000000, 5'd7,  '{sign: 1'b1, tag: 4'h2}, 1, "mulh_min");
    run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd12, '{sign: 1'b0, tag: 4'h4}, 0, "mulhu_max");
    run_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd31, '{sign: 1'b0, tag: 4'h8}, 2, "mulhsu_m1");
  endtask

  task automatic test_grant_hold();
    m_lat = 2;
    run_op(3'd1, 32'h12345678, 32'h9ABCDEF0, 5'd9, '{sign: 1'b0, tag: 4'h3}, 10, "grant_hold");
  endtask

  task automatic test_flush_wait();
    int s0, t0;
    logic seen;
    branch_tag_t tg;
    tg = '{sign: 1'b0, tag: 4'b0110};
    m_lat = 20;
    accept_op(3'd0, 32'd100, 32'd200, 5'd4, tg, "flush_wait", s0, t0);
    check_start(3'd0, 32'd100, 32'd200, tg, "flush_wait");
    repeat (4) @(negedge clk);
    flush = 1'b1; flush_tag = '{sign: 1'b0, tag: 4'b0010};
    @(negedge clk);
    flush = 1'b0;
    #1;
    total++;
    if (issue_ready !== 1'b1) begin bad++; $display("FAIL flush_wait ready: got %b want 1", issue_ready); end
    seen = 1'b0;
    for (int i = 0; i < 25; i++) begin @(negedge clk); #1; if (cdb_req === 1'b1) seen = 1'b1; end
    total++;
    if (seen !== 1'b0 || taken_cnt != t0) begin
      bad++; $display("FAIL flush_wait squash: req_seen/taken got %b/%0d want 0/0", seen, taken_cnt - t0);
    end
    m_lat = 3;
    run_op(3'd0, 32'd2, 32'd3, 5'd5, tg, 0, "after_flush");
  endtask

  task automatic test_flush_start();
    int s0, t0;
    branch_tag_t tg;
    tg = '{sign: 1'b0, tag: 4'b0011};
    m_lat = 5;
    accept_op(3'd1, 32'hDEADBEEF, 32'h00001234, 5'd17, tg, "flush_start", s0, t0);
    flush = 1'b1; flush_tag = '{sign: 1'b0, tag: 4'b0100};
    #1;
    total++;
    if (mul_start !== 1'b0) begin bad++; $display("FAIL flush_start hold: mul_start got %b want 0", mul_start); end
    @(negedge clk);
    flush = 1'b0;
    #1;
    check_start(3'd1, 32'hDEADBEEF, 32'h00001234, tg, "flush_start_retry");
    finish_op(ref_result(3'd1, 32'hDEADBEEF, 32'h00001234), 5'd17, s0, t0, 0, "flush_start");
  endtask

  task automatic test_flush_idle();
    @(negedge clk);
    flush = 1'b1; flush_tag = '{sign: 1'b1, tag: 4'hF};
    issue_valid = 1'b1; issue_funct3 = 3'd0;
    #1;
    total++;
    if (issue_ready !== 1'b0) begin bad++; $display("FAIL flush_idle: issue_ready got %b want 0", issue_ready); end
    @(negedge clk);
    flush = 1'b0; issue_valid = 1'b0;
    #1;
    total++;
    if (mul_start !== 1'b0 || issue_ready !== 1'b1) begin
      bad++; $display("FAIL flush_idle accept: start/ready got %b/%b want 0/1", mul_start, issue_ready);
    end
  endtask

  task automatic test_kill_resp();
    int s0, t0, k;
    branch_tag_t tg;
    tg = '{sign: 1'b0, tag: 4'b0011};
    m_lat = 2;
    accept_op(3'd3, 32'd55, 32'd66, 5'd21, tg, "kill_resp", s0, t0);
    k = 0;
    while (cdb_req !== 1'b1 && k < 50) begin @(negedge clk); #1; k++; end
    total++;
    if (cdb_req !== 1'b1) begin bad++; $display("FAIL kill_resp reach: cdb_req got %b want 1", cdb_req); end
    flush = 1'b1; flush_tag = '{sign: 1'b1, tag: 4'b0111};
    cdb_grant = 1'b1;
    #1;
    total++;
    if (cdb_req !== 1'b0) begin bad++; $display("FAIL kill_resp req: got %b want 0", cdb_req); end
    @(negedge clk);
    flush = 1'b0; cdb_grant = 1'b0;
    #1;
    total++;
    if (issue_ready !== 1'b1 || cdb_req !== 1'b0) begin
      bad++; $display("FAIL kill_resp idle: ready/req got %b/%b want 1/0", issue_ready, cdb_req);
    end
  endtask

  task automatic test_reset_mid();
    int s0, t0;
    m_lat = 30;
    accept_op(3'd2, 32'h7, 32'h9, 5'd11, '{sign: 1'b1, tag: 4'h5}, "reset_mid", s0, t0);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    total++;
    if ({issue_ready, mul_start, mul_type, mul_a, mul_b, mul_br_tag, mul_result_taken,
         cdb_req, cdb_rob_idx, cdb_data} !== '0) begin
      bad++; $display("FAIL reset_mid outputs: got nonzero (a=%h type=%b) want all 0", mul_a, mul_type);
    end
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    total++;
    if (issue_ready !== 1'b1) begin bad++; $display("FAIL reset_mid release: issue_ready got %b want 1", issue_ready); end
  endtask

  task automatic test_random();
    logic [31:0] corners [6];
    logic [31:0] a, b;
    logic [2:0]  f3;
    branch_tag_t tg;
    corners[0] = 32'h0; corners[1] = 32'h1; corners[2] = 32'hFFFFFFFF;
    corners[3] = 32'h80000000; corners[4] = 32'h7FFFFFFF; corners[5] = 32'hAAAA5555;
    for (int i = 0; i < 24; i++) begin
      f3 = 3'($urandom_range(0, 3));
      a = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
      tg.sign = 1'($urandom_range(0, 1));
      tg.tag  = 4'($urandom);
      m_lat = $urandom_range(1, 8);
      run_op(f3, a, b, 5'($urandom), tg, $urandom_range(0, 3), "random");
    end
  endtask

  task automatic test_long_latency();
    m_lat = 65;
    run_op(3'd3, 32'hCAFEF00D, 32'h0BADBEEF, 5'd30, '{sign: 1'b0, tag: 4'h9}, 0, "long_latency");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_grant_hold();
    test_flush_wait();
    test_flush_start();
    test_flush_idle();
    test_kill_resp();
    test_reset_mid();
    test_random();
    test_long_latency();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
